// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall and flush decisions for the five-stage MIPS pipeline.
// It combines three things: register-operand hazards (Tuse/Tnew), MDU occupancy
// and exception requests. It drives the PC, F/D and D/E enables and clears,
// keeps the MDU busy countdown, and counts stalled cycles in a saturating counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0]  MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0]  DIV_LD  = 4'(DIV_CYC);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt_q;
  logic        md_go;
  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;

  // A source operand is hazardous when a producer in E or M has a result that
  // becomes forwardable later than the D instruction needs it. Register 0 and
  // tuse 3 (operand unused) never stall. Because of the register-0 check,
  // E_wa/M_wa = 0 ("no write") can never match.
  function automatic logic operand_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic hit_e;
    logic hit_m;
    hit_e = (addr == e_wa) && (tuse < e_tnew);
    hit_m = (addr == m_wa) && (tuse < m_tnew);
    return (addr != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  // Combine the stall sources. An exception request overrides every one of them,
  // because the pipeline registers perform their own flush and vector load.
  always_comb begin
    md_go    = E_md_start & ~Req;
    md_busy  = (md_cnt != 4'd0) | md_go;
    stall_rs = operand_hazard(D_rs_addr, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew);
    stall_rt = operand_hazard(D_rt_addr, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew);
    stall_md = D_md & md_busy;
    stall    = (stall_rs | stall_rt | stall_md) & ~Req;
    PC_en    = ~stall;
    FD_en    = ~stall;
    DE_clr   = stall;
  end

  // MDU countdown. A new start reloads the counter and never accumulates.
  // A start flushed by Req is dropped, while a countdown already in flight
  // keeps running because the MDU itself is not aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (md_go) begin
      md_cnt <= E_md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Stalled-cycle statistics. The counter sticks at all-ones and never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vectors, multi-cycle sequences and random
// stimulus for pipe_stall_ctrl, checked against a cycle-indexed reference model.
module tb_pipe_stall_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_md, E_md_start, E_md_div;
  logic        PC_en, FD_en, DE_clr, md_busy;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .E_wa(E_wa), .M_wa(M_wa), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .D_md(D_md), .E_md_start(E_md_start), .E_md_div(E_md_div),
    .PC_en(PC_en), .FD_en(FD_en), .DE_clr(DE_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: the MDU is busy through cycle busy_until,
  // and the stall count is a plain saturating integer.
  int     cyc = 0;
  int     busy_until = -1;
  longint m_cnt = 0;
  bit     model_on = 1'b0;

  typedef struct {
    logic [4:0] rs;
    logic [1:0] rs_tuse;
    logic [4:0] rt;
    logic [1:0] rt_tuse;
    logic [4:0] ewa;
    logic [1:0] etnew;
    logic [4:0] mwa;
    logic [1:0] mtnew;
    logic       req;
    logic       stall;
  } vec_t;

  vec_t tbl[12];

  function automatic bit hz(input logic [4:0] a, input logic [1:0] tu,
                            input logic [4:0] ew, input logic [1:0] et,
                            input logic [4:0] mw, input logic [1:0] mt);
    int need;
    need = int'(tu);
    if (a == 5'd0 || tu == 2'd3) return 1'b0;
    if (a == ew && need < int'(et)) return 1'b1;
    if (a == mw && need < int'(mt)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [35:0] exp, input logic [35:0] act);
    logic [35:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, e);
    end
  endtask

  // Driver tasks
  task automatic idle();
    Req = 0; D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
    D_md = 0; E_md_start = 0; E_md_div = 0;
  endtask

  task automatic load_use();
    E_wa = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd1;
  endtask

  // One clock cycle: settle, compare against the model and optional constants,
  // then cross the rising edge and advance the model.
  task automatic tick(input string name, input bit use_f, input logic [3:0] exp_f,
                      input bit use_c, input logic [31:0] exp_c);
    bit m_start, m_busy, m_stall;
    logic [35:0] act;
    #1;
    act = {PC_en, FD_en, DE_clr, md_busy, stall_cnt};
    m_start = E_md_start && !Req;
    m_busy  = (cyc <= busy_until) || m_start;
    m_stall = (hz(D_rs_addr, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew) ||
               hz(D_rt_addr, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew) ||
               (D_md && m_busy)) && !Req;
    if (model_on)
      check({name, "/model"}, {!m_stall, !m_stall, m_stall, m_busy, 32'(m_cnt)}, act);
    if (use_f) check({name, "/flags"}, {exp_f, 32'd0}, {act[35:32], 32'd0});
    if (use_c) check({name, "/cnt"}, {4'd0, exp_c}, {4'd0, act[31:0]});
    @(posedge clk);
    if (reset) begin
      m_cnt = 0;
      busy_until = -1;
    end else begin
      if (m_start) busy_until = cyc + (E_md_div ? DIV_CYC : MULT_CYC);
      if (m_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick("rst", 0, 4'd0, 0, 32'd0);
    reset = 0;
  endtask

  initial begin
    // {rs, rs_tuse, rt, rt_tuse, ewa, etnew, mwa, mtnew, req, stall}
    tbl[0]  = '{5'd8,  2'd1, 5'd0,  2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{5'd8,  2'd1, 5'd0,  2'd3, 5'd0,  2'd0, 5'd8, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{5'd0,  2'd1, 5'd0,  2'd3, 5'd0,  2'd2, 5'd0, 2'd2, 1'b0, 1'b0};
    tbl[3]  = '{5'd8,  2'd3, 5'd0,  2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{5'd0,  2'd3, 5'd9,  2'd0, 5'd0,  2'd0, 5'd9, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{5'd0,  2'd3, 5'd9,  2'd1, 5'd0,  2'd0, 5'd9, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{5'd5,  2'd0, 5'd0,  2'd3, 5'd5,  2'd1, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[7]  = '{5'd5,  2'd0, 5'd0,  2'd3, 5'd6,  2'd2, 5'd7, 2'd2, 1'b0, 1'b0};
    tbl[8]  = '{5'd8,  2'd1, 5'd0,  2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{5'd0,  2'd3, 5'd31, 2'd0, 5'd31, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{5'd4,  2'd2, 5'd0,  2'd3, 5'd4,  2'd3, 5'd0, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{5'd4,  2'd2, 5'd0,  2'd3, 5'd0,  2'd0, 5'd4, 2'd2, 1'b0, 1'b0};

    idle();
    reset = 1;
    @(negedge clk);
    tick("reset0", 0, 4'd0, 0, 32'd0);
    model_on = 1'b1;
    tick("reset1", 1, 4'b1100, 1, 32'd0);
    reset = 0;
    tick("post_reset", 1, 4'b1100, 1, 32'd0);

    // Load-use: exactly one stall, then forwarding from M covers it
    load_use();
    tick("load_use", 1, 4'b0010, 1, 32'd0);
    E_wa = 0; E_tnew = 0; M_wa = 5'd8; M_tnew = 2'd1;
    tick("load_use_next", 1, 4'b1100, 1, 32'd1);
    idle(); load_use(); D_rs_addr = 5'd0;
    tick("rs_zero", 1, 4'b1100, 1, 32'd1);

    // Directed hazard table, MDU idle
    foreach (tbl[i]) begin
      idle();
      D_rs_addr = tbl[i].rs; D_rs_tuse = tbl[i].rs_tuse;
      D_rt_addr = tbl[i].rt; D_rt_tuse = tbl[i].rt_tuse;
      E_wa = tbl[i].ewa; E_tnew = tbl[i].etnew;
      M_wa = tbl[i].mwa; M_tnew = tbl[i].mtnew;
      Req = tbl[i].req;
      tick($sformatf("tbl%0d", i), 1, tbl[i].stall ? 4'b0010 : 4'b1100, 0, 32'd0);
    end

    // Divide busy with D_md held: stall cycles 0..10
    do_reset();
    E_md_start = 1; E_md_div = 1; D_md = 1;
    tick("div_c0", 1, 4'b0011, 1, 32'd0);
    E_md_start = 0;
    for (int c = 1; c <= 10; c++) tick($sformatf("div_c%0d", c), 1, 4'b0011, 1, 32'(c));
    tick("div_c11", 1, 4'b1100, 1, 32'd11);

    // Multiply at cycle 0, divide reload at cycle 2: busy through cycle 12
    do_reset();
    E_md_start = 1; E_md_div = 0;
    tick("mr_c0", 1, 4'b1101, 1, 32'd0);
    E_md_start = 0;
    tick("mr_c1", 1, 4'b1101, 1, 32'd0);
    E_md_start = 1; E_md_div = 1;
    tick("mr_c2", 1, 4'b1101, 1, 32'd0);
    E_md_start = 0; E_md_div = 0;
    for (int c = 3; c <= 12; c++) tick($sformatf("mr_c%0d", c), 1, 4'b1101, 1, 32'd0);
    tick("mr_c13", 1, 4'b1100, 1, 32'd0);

    // Req beats a load-use hazard and cancels a start
    do_reset();
    load_use(); E_md_start = 1; Req = 1;
    tick("req_win", 1, 4'b1100, 1, 32'd0);
    idle();
    tick("req_cancel", 1, 4'b1100, 1, 32'd0);
    // Req during a countdown (md_cnt = 3) leaves it running
    E_md_start = 1;
    tick("rq_c0", 1, 4'b1101, 1, 32'd0);
    E_md_start = 0;
    tick("rq_c1", 1, 4'b1101, 1, 32'd0);
    tick("rq_c2", 1, 4'b1101, 1, 32'd0);
    Req = 1; D_md = 1;
    tick("rq_c3", 1, 4'b1101, 1, 32'd0);
    Req = 0; D_md = 0;
    tick("rq_c4", 1, 4'b1101, 1, 32'd0);
    tick("rq_c5", 1, 4'b1101, 1, 32'd0);
    tick("rq_c6", 1, 4'b1100, 1, 32'd0);

    // Saturation of the stall counter
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    release dut.stall_cnt_q;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    load_use();
    tick("sat0", 1, 4'b0010, 1, 32'hFFFF_FFFE);
    tick("sat1", 1, 4'b0010, 1, 32'hFFFF_FFFF);
    tick("sat2", 1, 4'b0010, 1, 32'hFFFF_FFFF);
    idle();
    tick("sat3", 1, 4'b1100, 1, 32'hFFFF_FFFF);

    // Reset in the middle of a divide countdown
    do_reset();
    E_md_start = 1; E_md_div = 1;
    tick("rd_c0", 1, 4'b1101, 1, 32'd0);
    idle();
    for (int c = 1; c <= 3; c++) tick($sformatf("rd_c%0d", c), 1, 4'b1101, 1, 32'd0);
    reset = 1;
    tick("rd_rst", 1, 4'b1101, 0, 32'd0);
    reset = 0;
    tick("rd_after", 1, 4'b1100, 1, 32'd0);

    // Randomized stimulus against the reference model
    for (int n = 0; n < 800; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      Req        = ($urandom_range(0, 7) == 0);
      D_rs_addr  = 5'($urandom_range(0, 3));
      D_rt_addr  = 5'($urandom_range(0, 3));
      D_rs_tuse  = 2'($urandom_range(0, 3));
      D_rt_tuse  = 2'($urandom_range(0, 3));
      E_wa       = 5'($urandom_range(0, 3));
      M_wa       = 5'($urandom_range(0, 3));
      E_tnew     = 2'($urandom_range(0, 3));
      M_tnew     = 2'($urandom_range(0, 3));
      D_md       = 1'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 5) == 0);
      E_md_div   = 1'($urandom_range(0, 1));
      tick("rand", 0, 4'd0, 0, 32'd0);
    end
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It decides each cycle whether the F/D boundary holds, and whether a bubble goes into D/E, based on three inputs: register-operand hazards (Tuse/Tnew), multiply/divide unit occupancy and exception requests. It keeps an internal MDU busy countdown and a saturating stall statistics counter. It drives the enables and clears of the PC, F/D and D/E pipeline registers and sits beside the datapath in the CPU top.

## Interface
- MULT_CYC, 5: E-stage-to-result cycles for mult/multu.
- DIV_CYC, 10: E-stage-to-result cycles for div/divu.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Req  in  1  exception/interrupt taken this cycle (from CP0, M stage).
- D_rs_addr, D_rt_addr  in  5 each  D-stage source register numbers.
- D_rs_tuse, D_rt_tuse  in  2 each  cycles until the D instruction needs the operand, 0..2; 3 means unused.
- E_wa, M_wa  in  5 each  destination register of the E and M instructions; 0 means no write.
- E_tnew, M_tnew  in  2 each  cycles until that stage's result is forwardable; 0 means ready.
- D_md  in  1  D instruction uses the MDU (mult/div/mf*/mt*).
- E_md_start  in  1  E instruction starts a multiply or divide this cycle.
- E_md_div  in  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- PC_en  out  1  PC register load enable.
- FD_en  out  1  F/D register load enable.
- DE_clr  out  1  D/E register bubble insert; the D/E register keeps PC/BD.
- md_busy  out  1  MDU occupied (cycle counter nonzero or start this cycle).
- stall_cnt  out  32  count of stalled cycles, saturating.

## Operation
- The rs hazard (stall_rs) asserts when all of these hold:
  - D_rs_addr != 0 and D_rs_tuse != 3.
  - Either (D_rs_addr == E_wa and D_rs_tuse < E_tnew) or (D_rs_addr == M_wa and D_rs_tuse < M_tnew).
- The rt hazard (stall_rt) uses the same rule with the rt fields.
- stall_md = D_md & md_busy.
- stall = (stall_rs | stall_rt | stall_md) & ~Req.
- Outputs are combinational from inputs and state:
  - PC_en = ~stall.
  - FD_en = ~stall.
  - DE_clr = stall.
- On Req, all three outputs take their non-stall values. The pipeline registers perform their own exception flush and vector load, so Req always wins over every stall source.
- MDU counter md_cnt is 4 bits wide:
  - On reset, load 0.
  - Otherwise, if E_md_start & ~Req, load DIV_CYC when E_md_div = 1, else MULT_CYC.
  - Otherwise, if md_cnt != 0, decrement by 1.
  - Otherwise, hold.
- md_busy = (md_cnt != 0) | (E_md_start & ~Req).
- A start coinciding with Req is cancelled: the counter is not loaded, because the E instruction is flushed. A countdown already in progress continues through Req, since the MDU is not aborted.
- stall_cnt:
  - On reset, load 0.
  - Otherwise, when stall = 1 and stall_cnt != 32'hFFFFFFFF, increment.
  - Otherwise, hold. It never wraps.

## Timing
- Reset values:
  - md_cnt = 0, stall_cnt = 0, md_busy = 0.
  - With idle inputs: PC_en = 1, FD_en = 1, DE_clr = 0.
- Combinational path: inputs to PC_en/FD_en/DE_clr/md_busy with zero latency, in the same cycle.
- Multiply started at edge-cycle t (E_md_start high in cycle t):
  - md_busy is high in cycle t and in cycles t+1..t+5 (md_cnt 5..1).
  - md_busy is low at t+6.
- Divide is the same with 10 counting cycles.
- Back-to-back start while busy reloads the counter from the new value. No accumulation.
- A load-use pair (lw in E with E_tnew = 2, dependent addu in D with tuse 1) produces exactly one stall cycle:
  - The next cycle shows M_tnew = 1 and tuse 1, so there is no stall.
- A reset asserted mid-countdown clears md_cnt on that edge. md_busy is 0 the following cycle.
- A stall in the same cycle as Req produces no stall, and stall_cnt does not increment.

## Test plan
- Reset: hold reset 2 cycles with all inputs 0 -> PC_en = 1, FD_en = 1, DE_clr = 0, md_busy = 0, stall_cnt = 0.
- Load-use: E_wa = 8, E_tnew = 2, D_rs_addr = 8, D_rs_tuse = 1 -> one cycle with PC_en = 0, FD_en = 0, DE_clr = 1, stall_cnt = 1. The next cycle, with M_wa = 8 and M_tnew = 1, has no stall. Repeating with D_rs_addr = 0 gives no stall.
- Divide busy: E_md_start = 1, E_md_div = 1 at cycle 0, then D_md = 1 held -> stall in cycles 0..10, no stall in cycle 11, stall_cnt = 11.
- Multiply then reload: multiply start at cycle 0, divide start at cycle 2 -> md_busy high through cycle 12, low in cycle 13.
- Req priority: Req = 1 together with a load-use hazard and E_md_start = 1 -> PC_en = 1, FD_en = 1, DE_clr = 0, and md_cnt remains 0 the following cycle. Req during a countdown (md_cnt = 3) leaves the countdown unaffected.
- Saturation and reset: force stall_cnt to 32'hFFFFFFFE and keep stall high for 3 cycles -> stall_cnt holds 32'hFFFFFFFF. Reset during a divide countdown -> md_busy = 0 on the next cycle.
